// File: rtl/edram_pkg.sv
// Shared types and defaults for the eDRAM wordline sequencer slice.
package edram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WL_ON = 2'd1,
    PRECH = 2'd2
  } seq_state_t;

  localparam int DEF_ROW_BITS  = 8;
  localparam int DEF_NUM_BANKS = 4;

  // Wordline/bank_sel registers are only reloaded on WL_ON entry and exit.
  localparam bit LP_HOLD_DRIVE_REGS = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wl_onehot_dec.sv
// Combinational binary-to-one-hot decoder with enable; no state, no backpressure.
module wl_onehot_dec #(
  parameter int IN_BITS = 8,
  parameter int OUT_W   = 256
) (
  input  logic               en,
  input  logic [IN_BITS-1:0] idx,
  output logic [OUT_W-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      onehot[i] = en && (idx == IN_BITS'(i));
    end
  end

endmodule

// File: rtl/wordline_sequencer.sv
// Wordline sequencer: WL_ON_CYCLES of one-hot wordline, then PRECHARGE_CYCLES of precharge, one IDLE between ops;
// req_ready only in IDLE. Refresh arbitration/ref_row counter compiled in with REFRESH_CTR_EN.
module wordline_sequencer
  import edram_pkg::*;
#(
  parameter int ROW_BITS         = DEF_ROW_BITS,
  parameter int NUM_BANKS        = DEF_NUM_BANKS,
  parameter int WL_ON_CYCLES     = 4,
  parameter int PRECHARGE_CYCLES = 2,
  localparam int ROWS            = 2**ROW_BITS,
  localparam int BANK_BITS       = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ROW_BITS-1:0]  req_row,
  input  logic [BANK_BITS-1:0] req_bank,
  input  logic                 ref_req,
  output logic                 ref_ack,
  output logic [ROWS-1:0]      wordline,
  output logic [NUM_BANKS-1:0] bank_sel,
  output logic                 precharge,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = $clog2(max2(WL_ON_CYCLES, PRECHARGE_CYCLES)) + 1;

  seq_state_t           state, state_nxt;
  logic [CNT_W-1:0]     cnt;
  logic                 ref_go;
  logic                 start;
  logic                 wl_on_end;
  logic                 prech_end;
  logic [ROW_BITS-1:0]  act_row;
  logic [ROWS-1:0]      row_onehot;
  logic [NUM_BANKS-1:0] bank_onehot;

  assign start     = (state == IDLE) && (ref_go || req_valid);
  assign wl_on_end = (state == WL_ON) && (cnt == '0);
  assign prech_end = (state == PRECH) && (cnt == '0);

`ifdef REFRESH_CTR_EN
  logic [ROW_BITS-1:0] ref_row;
  logic                is_ref;

  assign ref_go  = ref_req;
  assign act_row = ref_go ? ref_row : req_row;
  assign ref_ack = prech_end && is_ref;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_ref  <= 1'b0;
      ref_row <= '0;
    end else begin
      if (start) is_ref <= ref_go;
      if (prech_end && is_ref) ref_row <= ref_row + 1'b1;
    end
  end
`else
  logic unused_ref;

  assign unused_ref = ref_req;
  assign ref_go     = 1'b0;
  assign act_row    = req_row;
  assign ref_ack    = 1'b0;
`endif

  wl_onehot_dec #(.IN_BITS(ROW_BITS), .OUT_W(ROWS)) u_row_dec (
    .en     (1'b1),
    .idx    (act_row),
    .onehot (row_onehot)
  );

  wl_onehot_dec #(.IN_BITS(BANK_BITS), .OUT_W(NUM_BANKS)) u_bank_dec (
    .en     (1'b1),
    .idx    (req_bank),
    .onehot (bank_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)          state_nxt = WL_ON;
      WL_ON:   if (cnt == '0)      state_nxt = PRECH;
      PRECH:   if (cnt == '0)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && !ref_go;
    busy      = (state != IDLE);
    precharge = (state == PRECH);
    done      = prech_end;
  end

  // Drive registers touched only on WL_ON entry/exit to keep the wide buses quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      wordline <= '0;
      bank_sel <= '0;
    end else begin
      if (start) begin
        cnt      <= CNT_W'(WL_ON_CYCLES - 1);
        wordline <= row_onehot;
        bank_sel <= bank_onehot | {NUM_BANKS{ref_go}};
      end else if (wl_on_end) begin
        cnt      <= CNT_W'(PRECHARGE_CYCLES - 1);
        wordline <= '0;
        bank_sel <= '0;
      end else if ((state != IDLE) && (cnt != '0)) begin
        cnt      <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wordline_sequencer.sv
// Directed bench for wordline_sequencer (8 row bits, 4 banks, 4 on / 2 precharge cycles).
module tb_wordline_sequencer;

  localparam int W = 4;
  localparam int P = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [7:0]   req_row;
  logic [1:0]   req_bank;
  logic         ref_req;
  logic         ref_ack;
  logic [255:0] wordline;
  logic [3:0]   bank_sel;
  logic         precharge;
  logic         busy;
  logic         done;

  int checks   = 0;
  int failures = 0;

  wordline_sequencer #(
    .ROW_BITS(8), .NUM_BANKS(4), .WL_ON_CYCLES(W), .PRECHARGE_CYCLES(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_row(req_row), .req_bank(req_bank), .ref_req(ref_req), .ref_ack(ref_ack),
    .wordline(wordline), .bank_sel(bank_sel), .precharge(precharge),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] row_bit(input int r);
    logic [255:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  // Called one step after the accepting edge; ends in the following IDLE cycle.
  task automatic run_op(input int row, input logic [3:0] bsel, input bit is_ref,
                        input int raise_k, input int drop_k);
    logic exp_rdy;
    for (int k = 1; k <= W + P; k++) begin
      chk("wordline",  wordline,  (k <= W) ? row_bit(row) : 256'd0);
      chk("bank_sel",  {252'd0, bank_sel}, (k <= W) ? {252'd0, bsel} : 256'd0);
      chk("precharge", {255'd0, precharge}, {255'd0, (k > W)});
      chk("busy",      {255'd0, busy}, 256'd1);
      chk("done",      {255'd0, done}, {255'd0, (k == W + P)});
      chk("ref_ack",   {255'd0, ref_ack}, {255'd0, (is_ref && k == W + P)});
      chk("ready_op",  {255'd0, req_ready}, 256'd0);
      if (k == raise_k) ref_req = 1'b1;
      if (k == drop_k)  ref_req = 1'b0;
      tick();
    end
`ifdef REFRESH_CTR_EN
    exp_rdy = !ref_req;
`else
    exp_rdy = 1'b1;
`endif
    chk("busy_idle",  {255'd0, busy}, 256'd0);
    chk("ready_idle", {255'd0, req_ready}, {255'd0, exp_rdy});
    chk("wl_idle",    wordline, 256'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_row = '0; req_bank = '0; ref_req = 1'b0;
    tick(); tick();
    chk("rst_wordline", wordline, 256'd0);
    chk("rst_bank_sel", {252'd0, bank_sel}, 256'd0);
    chk("rst_busy",     {255'd0, busy}, 256'd0);
    chk("rst_done",     {255'd0, done}, 256'd0);
    chk("rst_ref_ack",  {255'd0, ref_ack}, 256'd0);
    chk("rst_prech",    {255'd0, precharge}, 256'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {255'd0, req_ready}, 256'd1);

    // Plain access: row 0x5A, bank 2.
    req_valid = 1'b1; req_row = 8'h5A; req_bank = 2'd2;
    tick();
    req_valid = 1'b0;
    run_op(90, 4'b0100, 1'b0, 0, 0);

`ifdef REFRESH_CTR_EN
    // Refresh and request together: refresh wins, request waits.
    ref_req = 1'b1; req_valid = 1'b1; req_row = 8'h33; req_bank = 2'd1;
    #1;
    chk("ready_ref_prio", {255'd0, req_ready}, 256'd0);
    tick();
    run_op(0, 4'b1111, 1'b1, 0, W + P);
    tick();
    req_valid = 1'b0;
    run_op(8'h33, 4'b0010, 1'b0, 0, 0);

    // Refresh raised mid-access, then dropped mid-refresh.
    req_valid = 1'b1; req_row = 8'h10; req_bank = 2'd3;
    tick();
    req_valid = 1'b0;
    run_op(8'h10, 4'b1000, 1'b0, 2, 0);
    tick();
    run_op(1, 4'b1111, 1'b1, 0, 2);

    // Remaining refreshes up to row 255, then wrap to row 0.
    for (int i = 2; i <= 256; i++) begin
      ref_req = 1'b1;
      tick();
      run_op(i % 256, 4'b1111, 1'b1, 0, W + P);
    end
`else
    // Refresh disabled: held ref_req must not block requests.
    ref_req = 1'b1;
    req_valid = 1'b1; req_row = 8'hC3; req_bank = 2'd1;
    #1;
    chk("ready_ref_ignored", {255'd0, req_ready}, 256'd1);
    tick();
    req_valid = 1'b0;
    run_op(8'hC3, 4'b0010, 1'b0, 0, 0);
    ref_req = 1'b0;
`endif

    // Asynchronous reset in the middle of WL_ON.
    req_valid = 1'b1; req_row = 8'h77; req_bank = 2'd0;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_wl", wordline, row_bit(8'h77));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_wl",   wordline, 256'd0);
    chk("async_busy", {255'd0, busy}, 256'd0);
    chk("async_bank", {252'd0, bank_sel}, 256'd0);
    chk("async_done", {255'd0, done}, 256'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", {255'd0, req_ready}, 256'd1);
`ifdef REFRESH_CTR_EN
    ref_req = 1'b1;
    tick();
    run_op(0, 4'b1111, 1'b1, 0, W + P);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
